// File: rtl/bp_cce_uncached_msg.sv
// Uncached-mode CCE message engine: turns LCE uncached requests into memory commands
// and the matching memory responses into LCE data / store-done commands, one at a time.
module bp_cce_uncached_msg #(
    parameter int unsigned paddr_width_p  = 40,
    parameter int unsigned lce_id_width_p = 4,
    parameter int unsigned cce_id_width_p = 4,
    parameter int unsigned data_width_p   = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [cce_id_width_p-1:0] cce_id_i,

    input  logic                      lce_req_v_i,
    output logic                      lce_req_yumi_o,
    input  logic [1:0]                lce_req_type_i,
    input  logic [lce_id_width_p-1:0] lce_req_src_i,
    input  logic [paddr_width_p-1:0]  lce_req_addr_i,
    input  logic [1:0]                lce_req_size_i,
    input  logic [data_width_p-1:0]   lce_req_data_i,

    output logic                      mem_cmd_v_o,
    input  logic                      mem_cmd_ready_i,
    output logic                      mem_cmd_type_o,
    output logic [paddr_width_p-1:0]  mem_cmd_addr_o,
    output logic [1:0]                mem_cmd_size_o,
    output logic [lce_id_width_p-1:0] mem_cmd_lce_o,
    output logic [data_width_p-1:0]   mem_cmd_data_o,

    input  logic                      mem_resp_v_i,
    output logic                      mem_resp_yumi_o,
    input  logic                      mem_resp_type_i,
    input  logic [paddr_width_p-1:0]  mem_resp_addr_i,
    input  logic [lce_id_width_p-1:0] mem_resp_lce_i,
    input  logic [data_width_p-1:0]   mem_resp_data_i,

    output logic                      lce_cmd_v_o,
    input  logic                      lce_cmd_ready_i,
    output logic [3:0]                lce_cmd_type_o,
    output logic [lce_id_width_p-1:0] lce_cmd_dst_o,
    output logic [cce_id_width_p-1:0] lce_cmd_src_o,
    output logic [paddr_width_p-1:0]  lce_cmd_addr_o,
    output logic [data_width_p-1:0]   lce_cmd_data_o,

    output logic                      outstanding_o
);

    localparam logic [3:0] lce_cmd_uc_data    = 4'd5;
    localparam logic [3:0] lce_cmd_uc_st_done = 4'd6;

    typedef enum logic [0:0] {
        e_ready     = 1'b0,
        e_wait_resp = 1'b1
    } state_e;

    state_e state_r;

    // Cached and uncached flavours of a request map to the same memory op, so only bit 0 matters.
    logic unused_req_type_hi;
    assign unused_req_type_hi = lce_req_type_i[1];

    // Handshakes and command fields; everything is forced idle while reset is held.
    always_comb begin
        lce_req_yumi_o  = 1'b0;
        mem_cmd_v_o     = 1'b0;
        mem_cmd_type_o  = 1'b0;
        mem_cmd_addr_o  = '0;
        mem_cmd_size_o  = 2'b00;
        mem_cmd_lce_o   = '0;
        mem_cmd_data_o  = '0;
        mem_resp_yumi_o = 1'b0;
        lce_cmd_v_o     = 1'b0;
        lce_cmd_type_o  = 4'd0;
        lce_cmd_dst_o   = '0;
        lce_cmd_src_o   = '0;
        lce_cmd_addr_o  = '0;
        lce_cmd_data_o  = '0;

        if (!reset_i) begin
            unique case (state_r)
                e_ready: begin
                    mem_cmd_v_o    = lce_req_v_i;
                    lce_req_yumi_o = lce_req_v_i & mem_cmd_ready_i;
                    if (lce_req_v_i) begin
                        mem_cmd_type_o = lce_req_type_i[0];
                        mem_cmd_addr_o = lce_req_addr_i;
                        mem_cmd_size_o = lce_req_size_i;
                        mem_cmd_lce_o  = lce_req_src_i;
                        mem_cmd_data_o = lce_req_data_i;
                    end
                end
                e_wait_resp: begin
                    lce_cmd_v_o     = mem_resp_v_i;
                    mem_resp_yumi_o = mem_resp_v_i & lce_cmd_ready_i;
                    if (mem_resp_v_i) begin
                        lce_cmd_type_o = mem_resp_type_i ? lce_cmd_uc_st_done : lce_cmd_uc_data;
                        lce_cmd_dst_o  = mem_resp_lce_i;
                        lce_cmd_src_o  = cce_id_i;
                        lce_cmd_addr_o = mem_resp_addr_i;
                        lce_cmd_data_o = mem_resp_type_i ? '0 : mem_resp_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single transaction in flight: advance only on the consuming handshake of each phase.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            unique case (state_r)
                e_ready:     if (lce_req_yumi_o)  state_r <= e_wait_resp;
                e_wait_resp: if (mem_resp_yumi_o) state_r <= e_ready;
                default:     state_r <= e_ready;
            endcase
        end
    end

    assign outstanding_o = (state_r == e_wait_resp);

endmodule

// File: tb/tb_bp_cce_uncached_msg.sv
// Directed bench for bp_cce_uncached_msg: load, store, backpressure, single-outstanding,
// stray response and asynchronous reset, each against hand-computed values.
module tb_bp_cce_uncached_msg;

    localparam int unsigned paddr_width_p  = 40;
    localparam int unsigned lce_id_width_p = 4;
    localparam int unsigned cce_id_width_p = 4;
    localparam int unsigned data_width_p   = 64;

    logic                      clk_i = 1'b0;
    logic                      reset_i;
    logic [cce_id_width_p-1:0] cce_id_i;
    logic                      lce_req_v_i;
    logic                      lce_req_yumi_o;
    logic [1:0]                lce_req_type_i;
    logic [lce_id_width_p-1:0] lce_req_src_i;
    logic [paddr_width_p-1:0]  lce_req_addr_i;
    logic [1:0]                lce_req_size_i;
    logic [data_width_p-1:0]   lce_req_data_i;
    logic                      mem_cmd_v_o;
    logic                      mem_cmd_ready_i;
    logic                      mem_cmd_type_o;
    logic [paddr_width_p-1:0]  mem_cmd_addr_o;
    logic [1:0]                mem_cmd_size_o;
    logic [lce_id_width_p-1:0] mem_cmd_lce_o;
    logic [data_width_p-1:0]   mem_cmd_data_o;
    logic                      mem_resp_v_i;
    logic                      mem_resp_yumi_o;
    logic                      mem_resp_type_i;
    logic [paddr_width_p-1:0]  mem_resp_addr_i;
    logic [lce_id_width_p-1:0] mem_resp_lce_i;
    logic [data_width_p-1:0]   mem_resp_data_i;
    logic                      lce_cmd_v_o;
    logic                      lce_cmd_ready_i;
    logic [3:0]                lce_cmd_type_o;
    logic [lce_id_width_p-1:0] lce_cmd_dst_o;
    logic [cce_id_width_p-1:0] lce_cmd_src_o;
    logic [paddr_width_p-1:0]  lce_cmd_addr_o;
    logic [data_width_p-1:0]   lce_cmd_data_o;
    logic                      outstanding_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    bp_cce_uncached_msg #(
        .paddr_width_p (paddr_width_p),
        .lce_id_width_p(lce_id_width_p),
        .cce_id_width_p(cce_id_width_p),
        .data_width_p  (data_width_p)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .cce_id_i       (cce_id_i),
        .lce_req_v_i    (lce_req_v_i),
        .lce_req_yumi_o (lce_req_yumi_o),
        .lce_req_type_i (lce_req_type_i),
        .lce_req_src_i  (lce_req_src_i),
        .lce_req_addr_i (lce_req_addr_i),
        .lce_req_size_i (lce_req_size_i),
        .lce_req_data_i (lce_req_data_i),
        .mem_cmd_v_o    (mem_cmd_v_o),
        .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_cmd_type_o (mem_cmd_type_o),
        .mem_cmd_addr_o (mem_cmd_addr_o),
        .mem_cmd_size_o (mem_cmd_size_o),
        .mem_cmd_lce_o  (mem_cmd_lce_o),
        .mem_cmd_data_o (mem_cmd_data_o),
        .mem_resp_v_i   (mem_resp_v_i),
        .mem_resp_yumi_o(mem_resp_yumi_o),
        .mem_resp_type_i(mem_resp_type_i),
        .mem_resp_addr_i(mem_resp_addr_i),
        .mem_resp_lce_i (mem_resp_lce_i),
        .mem_resp_data_i(mem_resp_data_i),
        .lce_cmd_v_o    (lce_cmd_v_o),
        .lce_cmd_ready_i(lce_cmd_ready_i),
        .lce_cmd_type_o (lce_cmd_type_o),
        .lce_cmd_dst_o  (lce_cmd_dst_o),
        .lce_cmd_src_o  (lce_cmd_src_o),
        .lce_cmd_addr_o (lce_cmd_addr_o),
        .lce_cmd_data_o (lce_cmd_data_o),
        .outstanding_o  (outstanding_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input logic v, input logic [1:0] typ, input logic [3:0] src,
                             input logic [39:0] addr, input logic [1:0] size, input logic [63:0] data);
        lce_req_v_i    = v;
        lce_req_type_i = typ;
        lce_req_src_i  = src;
        lce_req_addr_i = addr;
        lce_req_size_i = size;
        lce_req_data_i = data;
    endtask

    task automatic drive_resp(input logic v, input logic typ, input logic [3:0] lce,
                              input logic [39:0] addr, input logic [63:0] data);
        mem_resp_v_i    = v;
        mem_resp_type_i = typ;
        mem_resp_lce_i  = lce;
        mem_resp_addr_i = addr;
        mem_resp_data_i = data;
    endtask

    initial begin
        reset_i         = 1'b1;
        cce_id_i        = 4'd5;
        mem_cmd_ready_i = 1'b1;
        lce_cmd_ready_i = 1'b1;
        drive_req(1'b1, 2'd2, 4'd3, 40'h0080001000, 2'd3, 64'h0);
        drive_resp(1'b1, 1'b0, 4'd3, 40'h0080001000, 64'h1);

        // Reset holds every valid/yumi low even with both FIFOs non-empty
        #12;
        check("rst_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        check("rst_req_yumi", 64'(lce_req_yumi_o), 64'd0);
        check("rst_lce_cmd_v", 64'(lce_cmd_v_o), 64'd0);
        check("rst_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);

        // Uncached load; its response is already present in the same cycle
        settle();
        reset_i = 1'b0;
        drive_resp(1'b1, 1'b0, 4'd3, 40'h0080001000, 64'hDEADBEEF_01234567);
        #1;
        check("ld_mem_cmd_v", 64'(mem_cmd_v_o), 64'd1);
        check("ld_mem_cmd_type", 64'(mem_cmd_type_o), 64'd0);
        check("ld_mem_cmd_addr", 64'(mem_cmd_addr_o), 64'h80001000);
        check("ld_mem_cmd_size", 64'(mem_cmd_size_o), 64'd3);
        check("ld_mem_cmd_lce", 64'(mem_cmd_lce_o), 64'd3);
        check("ld_req_yumi", 64'(lce_req_yumi_o), 64'd1);
        check("ld_same_cycle_resp_v", 64'(lce_cmd_v_o), 64'd0);
        check("ld_same_cycle_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
        check("ld_outstanding_pre", 64'(outstanding_o), 64'd0);

        settle();
        drive_req(1'b0, 2'd0, 4'd0, 40'h0, 2'd0, 64'h0);
        #1;
        check("ld_outstanding", 64'(outstanding_o), 64'd1);
        check("ld_lce_cmd_v", 64'(lce_cmd_v_o), 64'd1);
        check("ld_lce_cmd_type", 64'(lce_cmd_type_o), 64'd5);
        check("ld_lce_cmd_dst", 64'(lce_cmd_dst_o), 64'd3);
        check("ld_lce_cmd_src", 64'(lce_cmd_src_o), 64'd5);
        check("ld_lce_cmd_addr", 64'(lce_cmd_addr_o), 64'h80001000);
        check("ld_lce_cmd_data", lce_cmd_data_o, 64'hDEADBEEF_01234567);
        check("ld_resp_yumi", 64'(mem_resp_yumi_o), 64'd1);
        check("ld_wait_no_cmd", 64'(mem_cmd_v_o), 64'd0);

        settle();
        drive_resp(1'b0, 1'b0, 4'd0, 40'h0, 64'h0);
        #1;
        check("ld_done_outstanding", 64'(outstanding_o), 64'd0);

        // Uncached store: response data is discarded in the store-done command
        drive_req(1'b1, 2'd3, 4'd7, 40'h0000001234, 2'd2, 64'h55);
        #1;
        check("st_mem_cmd_type", 64'(mem_cmd_type_o), 64'd1);
        check("st_mem_cmd_size", 64'(mem_cmd_size_o), 64'd2);
        check("st_mem_cmd_data", mem_cmd_data_o, 64'h55);
        check("st_req_yumi", 64'(lce_req_yumi_o), 64'd1);
        settle();
        drive_req(1'b0, 2'd0, 4'd0, 40'h0, 2'd0, 64'h0);
        drive_resp(1'b1, 1'b1, 4'd7, 40'h0000001234, 64'hFFFF_FFFF);
        #1;
        check("st_lce_cmd_type", 64'(lce_cmd_type_o), 64'd6);
        check("st_lce_cmd_dst", 64'(lce_cmd_dst_o), 64'd7);
        check("st_lce_cmd_data", lce_cmd_data_o, 64'd0);
        check("st_resp_yumi", 64'(mem_resp_yumi_o), 64'd1);
        settle();
        drive_resp(1'b0, 1'b0, 4'd0, 40'h0, 64'h0);

        // Memory-command backpressure: request held, no yumi, no state change
        drive_req(1'b1, 2'd0, 4'd2, 40'h00000A0000, 2'd1, 64'h0);
        mem_cmd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_mem_cmd_v", 64'(mem_cmd_v_o), 64'd1);
            check("bp_req_yumi", 64'(lce_req_yumi_o), 64'd0);
            check("bp_outstanding", 64'(outstanding_o), 64'd0);
            settle();
        end
        mem_cmd_ready_i = 1'b1;
        #1;
        check("bp_release_yumi", 64'(lce_req_yumi_o), 64'd1);
        settle();

        // A second request waits while the first is outstanding; LCE-command backpressure
        drive_req(1'b1, 2'd3, 4'd9, 40'h00000B0000, 2'd0, 64'hAB);
        drive_resp(1'b1, 1'b0, 4'd2, 40'h00000A0000, 64'h1111);
        lce_cmd_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("so_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
            check("so_req_yumi", 64'(lce_req_yumi_o), 64'd0);
            check("so_mem_cmd_addr", 64'(mem_cmd_addr_o), 64'd0);
            check("lbp_lce_cmd_v", 64'(lce_cmd_v_o), 64'd1);
            check("lbp_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
            check("lbp_outstanding", 64'(outstanding_o), 64'd1);
            settle();
        end
        lce_cmd_ready_i = 1'b1;
        #1;
        check("lbp_release_yumi", 64'(mem_resp_yumi_o), 64'd1);
        settle();
        drive_resp(1'b0, 1'b0, 4'd0, 40'h0, 64'h0);
        #1;
        check("so_second_accepted", 64'(lce_req_yumi_o), 64'd1);
        check("so_second_addr", 64'(mem_cmd_addr_o), 64'hB0000);
        settle();

        // Asynchronous reset mid-cycle while waiting for a response
        drive_req(1'b1, 2'd2, 4'd1, 40'h00000C0000, 2'd3, 64'h0);
        #1;
        check("ar_outstanding_pre", 64'(outstanding_o), 64'd1);
        #2;
        reset_i = 1'b1;
        drive_resp(1'b1, 1'b1, 4'd9, 40'h00000B0000, 64'h0);
        #1;
        check("ar_outstanding", 64'(outstanding_o), 64'd0);
        check("ar_mem_cmd_v", 64'(mem_cmd_v_o), 64'd0);
        check("ar_req_yumi", 64'(lce_req_yumi_o), 64'd0);
        check("ar_lce_cmd_v", 64'(lce_cmd_v_o), 64'd0);
        check("ar_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
        settle();
        reset_i = 1'b0;
        drive_req(1'b0, 2'd0, 4'd0, 40'h0, 2'd0, 64'h0);

        // Stray response while ready is left untouched
        #1;
        check("stray_lce_cmd_v", 64'(lce_cmd_v_o), 64'd0);
        check("stray_resp_yumi", 64'(mem_resp_yumi_o), 64'd0);
        check("stray_lce_cmd_data", lce_cmd_data_o, 64'd0);
        settle();
        drive_resp(1'b0, 1'b0, 4'd0, 40'h0, 64'h0);

        // New request accepted after reset release
        drive_req(1'b1, 2'd2, 4'd4, 40'h00000D0000, 2'd3, 64'h0);
        #1;
        check("post_rst_yumi", 64'(lce_req_yumi_o), 64'd1);
        settle();
        drive_req(1'b0, 2'd0, 4'd0, 40'h0, 2'd0, 64'h0);
        #1;
        check("post_rst_outstanding", 64'(outstanding_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bp_cce_uncached_msg.md
# bp_cce_uncached_msg

Uncached-mode message engine of the CCE. It converts each LCE uncached load/store request into a memory command, and converts the matching memory response into an LCE command (load data or store-done). It sits between the CCE's inbound LCE-request and memory-response FIFOs and its outbound LCE-command and memory-command ports. It is selected while the CCE is in uncached mode or while an uncached transaction is still outstanding.

## Interface
**Parameters**
- paddr_width_p, 40: physical address width.
- lce_id_width_p, 4: LCE id width.
- cce_id_width_p, 4: CCE id width.
- data_width_p, 64: data width, 64 only.

**Ports**
- Clock and reset: single clock domain; `reset_i` is asynchronous and active-high.
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- cce_id_i  in  cce_id_width_p  this CCE's id; driven into lce_cmd_src_o.
- lce_req_v_i  in  1  LCE request valid (FIFO head).
- lce_req_yumi_o  out  1  request consumed.
- lce_req_type_i  in  2  0=rd, 1=wr, 2=uc_rd, 3=uc_wr.
- lce_req_src_i  in  lce_id_width_p  requesting LCE.
- lce_req_addr_i  in  paddr_width_p  address.
- lce_req_size_i  in  2  0=1B, 1=2B, 2=4B, 3=8B.
- lce_req_data_i  in  64  store data, LSB-aligned.
- mem_cmd_v_o  out  1  memory command valid.
- mem_cmd_ready_i  in  1  memory command ready.
- mem_cmd_type_o  out  1  0=uc_rd, 1=uc_wr.
- mem_cmd_addr_o  out  paddr_width_p  address.
- mem_cmd_size_o  out  2  size.
- mem_cmd_lce_o  out  lce_id_width_p  requester id.
- mem_cmd_data_o  out  64  store data.
- mem_resp_v_i  in  1  memory response valid (FIFO head).
- mem_resp_yumi_o  out  1  response consumed.
- mem_resp_type_i  in  1  0=uc_rd, 1=uc_wr.
- mem_resp_addr_i  in  paddr_width_p  address.
- mem_resp_lce_i  in  lce_id_width_p  requester id.
- mem_resp_data_i  in  64  load data.
- lce_cmd_v_o  out  1  LCE command valid.
- lce_cmd_ready_i  in  1  LCE command ready.
- lce_cmd_type_o  out  4  5=uc_data, 6=uc_st_done.
- lce_cmd_dst_o  out  lce_id_width_p  destination LCE.
- lce_cmd_src_o  out  cce_id_width_p  = cce_id_i.
- lce_cmd_addr_o  out  paddr_width_p  address.
- lce_cmd_data_o  out  64  load data.
- outstanding_o  out  1  a memory command has been sent and its response has not yet been consumed.

## Operation
- One transaction in flight at a time. Two states: READY and WAIT_RESP. Reset state is READY.
- **READY**
  - mem_cmd_v_o = lce_req_v_i.
  - lce_req_yumi_o = lce_req_v_i & mem_cmd_ready_i.
  - Command fields are passed through combinationally: type = lce_req_type_i[0] (rd/uc_rd→uc_rd, wr/uc_wr→uc_wr), addr, size, lce = src, data.
  - On yumi, go to WAIT_RESP.
  - mem_resp_yumi_o = 0 and lce_cmd_v_o = 0. A stray response stays unconsumed.
- **WAIT_RESP**
  - lce_cmd_v_o = mem_resp_v_i.
  - mem_resp_yumi_o = mem_resp_v_i & lce_cmd_ready_i.
  - lce_cmd_type_o = uc_data if mem_resp_type_i=0, else uc_st_done.
  - dst = mem_resp_lce_i, addr = mem_resp_addr_i.
  - data = mem_resp_data_i for a read, 0 for a write.
  - On yumi, go to READY.
  - mem_cmd_v_o = 0 and lce_req_yumi_o = 0 in this state.
- Command outputs that are not valid are driven to 0.
- outstanding_o = (state == WAIT_RESP).
- While reset_i=1, every valid and yumi output is forced to 0.

## Timing
- Request to memory command: 0 cycles (combinational) when mem_cmd_ready_i=1.
- Memory response to LCE command: 0 cycles (combinational).
- The state register updates on the clk_i edge following the handshake.
- Fastest turnaround: request accepted in cycle N; a response can be forwarded in cycle N+1 at the earliest.
- Backpressure:
  - mem_cmd_ready_i=0 holds the request in the FIFO with no yumi.
  - lce_cmd_ready_i=0 holds the response with no yumi.
- A response arriving in the same cycle as its request is not consumed until cycle N+1.
- Reset asserted mid-transaction:
  - State is immediately cleared to READY and outstanding_o to 0.
  - The in-flight transaction is dropped.
  - Valid and yumi outputs go to 0 within the same cycle.

## Test plan
- **Uncached load:** req uc_rd, src=3, addr=0x80001000, size=3 with mem_cmd_ready_i=1 → same-cycle mem_cmd uc_rd with the same fields, yumi=1, outstanding_o=1 the next cycle. Then resp uc_rd with data 0xDEADBEEF_01234567 → lce_cmd uc_data, dst=3, src=cce_id_i, and the same data, addr and yumi in one cycle.
- **Uncached store:** req uc_wr, size=2, data=0x55 → mem_cmd uc_wr, data 0x55. Then resp uc_wr → lce_cmd uc_st_done with data 0.
- **Backpressure:** mem_cmd_ready_i=0 for 3 cycles → mem_cmd_v_o=1 and lce_req_yumi_o=0 throughout, state stays READY. With lce_cmd_ready_i=0 in WAIT_RESP → mem_resp_yumi_o=0 until ready.
- **Single outstanding:** a second request valid while in WAIT_RESP → mem_cmd_v_o=0 and no yumi until the first response is consumed.
- **Stray response in READY:** mem_resp_v_i=1 → lce_cmd_v_o=0, mem_resp_yumi_o=0.
- **Async reset:** reset asserted in WAIT_RESP between clock edges → outstanding_o=0 and all valid/yumi outputs 0 immediately. After release, a new request is accepted.
